// File: rtl/data_mem_responder.sv
// Data memory responder: a single-request load/store port in front of a
// word-organised RAM with byte lanes. A request is accepted in IDLE, waits
// LATENCY cycles in WAIT, and is answered in RESP until the core takes it.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT  = 4'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        load_q, load_d;

  // Operation seen by the RAM on the edge entering RESP
  logic          commit;
  logic          op_we;
  logic [2:0]    op_type;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic          op_err;
  logic [3:0]    op_be;
  logic [31:0]   op_lane_data;
  logic [AW-1:0] op_index;
  logic [31:0]   rd_word;

  // Operand source: with LATENCY=0 the RAM access happens on the accept edge,
  // so the live request is used; otherwise the captured copy is used.
  always_comb begin
    op_we    = we_q;
    op_type  = type_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state_q == IDLE) begin
      op_we    = req_we;
      op_type  = req_type;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end
  end

  // Request legality, byte-enable and lane-replicated store data
  always_comb begin
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (op_we) begin
      illegal = op_type[2] || (op_type[1:0] == 2'b11);
    end else begin
      illegal = (op_type == 3'b011) || (op_type[2:1] == 2'b11);
    end
    misaligned   = ((op_type[1:0] == 2'b01) && op_addr[0]) ||
                   ((op_type == 3'b010) && (op_addr[1:0] != 2'b00));
    out_of_range = (op_addr[31:2] >= DEPTH_LIM);
    op_err       = illegal || misaligned || out_of_range;
    op_index     = op_addr[AW+1:2];
    case (op_type[1:0])
      2'b00: begin
        op_be        = 4'b0001 << op_addr[1:0];
        op_lane_data = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        op_be        = op_addr[1] ? 4'b1100 : 4'b0011;
        op_lane_data = {2{op_wdata[15:0]}};
      end
      default: begin
        op_be        = 4'b1111;
        op_lane_data = op_wdata;
      end
    endcase
  end

  // Next-state logic: handshake, latency counter, request capture and response flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          type_d  = req_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    commit = (state_d == RESP) && (state_q != RESP);
    if (commit) begin
      err_d  = op_err;
      load_d = !op_we && !op_err;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  // Captured request fields; only consumed after acceptance, so no reset needed
  always_ff @(posedge CLK) begin
    we_q    <= we_d;
    type_q  <= type_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // One byte-wide RAM per lane; write and registered read on the commit edge.
  // Reset suppresses the commit so a dropped store never lands.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] rd_q;

      // Lane write and registered read
      always_ff @(posedge CLK) begin
        if (commit && !RESET && op_we && !op_err && op_be[gi]) begin
          lane_mem[op_index] <= op_lane_data[8*gi +: 8];
        end
        if (commit && !RESET) begin
          rd_q <= lane_mem[op_index];
        end
      end

      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  // Load formatting from the registered read word; zero for stores and errors
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    case (addr_q[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    rsp_rdata = 32'd0;
    if (load_q) begin
      case (type_q)
        3'b000:  rsp_rdata = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  rsp_rdata = {{16{half_sel[15]}}, half_sel};
        3'b010:  rsp_rdata = rd_word;
        3'b100:  rsp_rdata = {24'd0, byte_sel};
        3'b101:  rsp_rdata = {16'd0, half_sel};
        default: rsp_rdata = 32'd0;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;

endmodule
